// File: rtl/pong_match_ctrl.sv
// pong_match_ctrl: match sequencing for the pong game.
// Button synchronisation, IDLE/SERVE/RALLY/POINT/OVER flow, scoring and winner.
// Build option: define MATCH_PAUSE_EN to enable the pause button (RALLY <-> PAUSE).
module pong_match_ctrl #(
    parameter int unsigned WIN_SCORE    = 7,
    parameter int unsigned SERVE_FRAMES = 60,
    parameter int unsigned POINT_FRAMES = 90
) (
    input  logic       clk,
    input  logic       not_rst,
    input  logic       frame_tick,
    input  logic       start_n,
    input  logic       pause_n,
    input  logic       miss_left,
    input  logic       miss_right,
    output logic       run,
    output logic       serve,
    output logic       serve_dir,
    output logic [3:0] score_left,
    output logic [3:0] score_right,
    output logic [1:0] winner,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SERVE = 3'd1,
        ST_RALLY = 3'd2,
        ST_POINT = 3'd3,
        ST_OVER  = 3'd4,
        ST_PAUSE = 3'd5
    } state_t;

    localparam logic [3:0] WIN        = 4'(WIN_SCORE);
    localparam logic [7:0] SERVE_LAST = 8'(SERVE_FRAMES - 1);
    localparam logic [7:0] POINT_LAST = 8'(POINT_FRAMES - 1);

    state_t     r_state;
    state_t     w_next;
    logic       r_start_s1;
    logic       r_start_s2;
    logic       r_start_d;
    logic       w_start_evt;
    logic       w_pause_evt;
    logic [7:0] r_cnt;
    logic [3:0] r_score_l;
    logic [3:0] r_score_r;
    logic       r_serve_dir;
    logic       r_was_serve;
    logic       w_win_reached;

    // Start button: two-flop synchroniser plus a delay flop for press-edge detection
    always_ff @(posedge clk) begin
        if (!not_rst) begin
            r_start_s1 <= 1'b1;
            r_start_s2 <= 1'b1;
            r_start_d  <= 1'b1;
        end else begin
            r_start_s1 <= start_n;
            r_start_s2 <= r_start_s1;
            r_start_d  <= r_start_s2;
        end
    end

    assign w_start_evt = r_start_d & ~r_start_s2;

`ifdef MATCH_PAUSE_EN
    logic r_pause_s1;
    logic r_pause_s2;
    logic r_pause_d;

    // Pause button: same synchroniser and press-edge detection as start
    always_ff @(posedge clk) begin
        if (!not_rst) begin
            r_pause_s1 <= 1'b1;
            r_pause_s2 <= 1'b1;
            r_pause_d  <= 1'b1;
        end else begin
            r_pause_s1 <= pause_n;
            r_pause_s2 <= r_pause_s1;
            r_pause_d  <= r_pause_s2;
        end
    end

    assign w_pause_evt = r_pause_d & ~r_pause_s2;
`else
    logic w_pause_unused;
    assign w_pause_unused = pause_n;
    assign w_pause_evt    = 1'b0;
`endif

    assign w_win_reached = (r_score_l == WIN) || (r_score_r == WIN);

    // State register
    always_ff @(posedge clk) begin
        if (!not_rst) r_state <= ST_IDLE;
        else          r_state <= w_next;
    end

    // Next-state logic; a tick that ends SERVE/POINT is consumed by the state it ends
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (w_start_evt) w_next = ST_SERVE;
            ST_SERVE: if (frame_tick && r_cnt == SERVE_LAST) w_next = ST_RALLY;
            ST_RALLY: begin
                if (miss_left && miss_right)      w_next = ST_SERVE;
                else if (miss_left || miss_right) w_next = ST_POINT;
                else if (w_pause_evt)             w_next = ST_PAUSE;
            end
            ST_POINT: if (frame_tick && r_cnt == POINT_LAST)
                          w_next = w_win_reached ? ST_OVER : ST_SERVE;
            ST_OVER:  if (w_start_evt) w_next = ST_SERVE;
            ST_PAUSE: if (w_pause_evt) w_next = ST_RALLY;
            default:  w_next = ST_IDLE;
        endcase
    end

    // Frame counter, scores, serve direction and serve-entry tracking
    always_ff @(posedge clk) begin
        if (!not_rst) begin
            r_cnt       <= '0;
            r_score_l   <= '0;
            r_score_r   <= '0;
            r_serve_dir <= 1'b1;
            r_was_serve <= 1'b0;
        end else begin
            r_was_serve <= (r_state == ST_SERVE);
            if (w_next != r_state)
                r_cnt <= '0;
            else if (frame_tick && (r_state == ST_SERVE || r_state == ST_POINT))
                r_cnt <= r_cnt + 8'd1;
            if (r_state == ST_RALLY && miss_left && !miss_right) begin
                if (r_score_r != WIN) r_score_r <= r_score_r + 4'd1;
                r_serve_dir <= 1'b0;
            end
            if (r_state == ST_RALLY && miss_right && !miss_left) begin
                if (r_score_l != WIN) r_score_l <= r_score_l + 4'd1;
                r_serve_dir <= 1'b1;
            end
            if (r_state == ST_OVER && w_start_evt) begin
                r_score_l   <= '0;
                r_score_r   <= '0;
                r_serve_dir <= 1'b1;
            end
        end
    end

    // Outputs decoded from state and registers
    always_comb begin
        run         = (r_state == ST_RALLY);
        serve       = (r_state == ST_SERVE) && !r_was_serve;
        serve_dir   = r_serve_dir;
        score_left  = r_score_l;
        score_right = r_score_r;
        state       = r_state;
        winner      = 2'b00;
        if (r_state == ST_OVER) winner = {r_score_r == WIN, r_score_l == WIN};
    end

endmodule

// File: doc/pong_match_ctrl.md
PONG_MATCH_CTRL -- requirements
Module: pong_match_ctrl

Interface
REQ-001 SHALL have parameter WIN_SCORE, default 7, points needed to win a match (legal 1..15).
REQ-002 SHALL have parameter SERVE_FRAMES, default 60, frames the ball is held before release (legal 1..255).
REQ-003 SHALL have parameter POINT_FRAMES, default 90, frames frozen after a point (legal 1..255).
REQ-004 SHALL have port: clk  in  1  system clock (50 MHz domain, same as game logic).
REQ-005 SHALL have port: not_rst  in  1  reset, synchronous, active-low.
REQ-006 SHALL have port: frame_tick  in  1  one-cycle pulse per video frame.
REQ-007 SHALL have port: start_n  in  1  raw push button, active-low, asynchronous.
REQ-008 SHALL have port: pause_n  in  1  raw push button, active-low, asynchronous (ignored unless REQ-030 applies).
REQ-009 SHALL have port: miss_left  in  1  one-cycle pulse, ball passed left pad.
REQ-010 SHALL have port: miss_right  in  1  one-cycle pulse, ball passed right pad.
REQ-011 SHALL have port: run  out  1  high = game logic may move ball and pads.
REQ-012 SHALL have port: serve  out  1  one-cycle pulse, game logic recentres ball.
REQ-013 SHALL have port: serve_dir  out  1  0 = ball launches left, 1 = right.
REQ-014 SHALL have port: score_left, score_right  out  4 each  current points.
REQ-015 SHALL have port: winner  out  2  00 none, 01 left, 10 right.
REQ-016 SHALL have port: state  out  3  current FSM state encoding, for debug LEDs.

Function
REQ-017 SHALL synchronise start_n and pause_n through two flops, then detect the press (1->0) edge; one press yields exactly one one-cycle event.
REQ-018 SHALL implement states IDLE=0, SERVE=1, RALLY=2, POINT=3, OVER=4, PAUSE=5.
REQ-019 IDLE: run=0, scores held at 0, winner=00; start event -> SERVE.
REQ-020 On every entry to SERVE: serve pulses high for exactly the first cycle in SERVE; frame counter loads 0; run=0.
REQ-021 SERVE: counter increments on frame_tick; on the tick that makes it equal SERVE_FRAMES -> RALLY next cycle.
REQ-022 RALLY: run=1; miss_left alone -> score_right+1, serve_dir<=0, POINT; miss_right alone -> score_left+1, serve_dir<=1, POINT.
REQ-023 RALLY: miss_left and miss_right in same cycle -> no score change, serve_dir unchanged, SERVE (let).
REQ-024 POINT: run=0, counter counts frame_tick from 0; at POINT_FRAMES -> OVER if either score equals WIN_SCORE, else SERVE.
REQ-025 OVER: run=0, winner set to side with WIN_SCORE, scores held; start event -> clear scores, winner=00, serve_dir=1, SERVE.
REQ-026 Miss pulses outside RALLY SHALL be ignored; start events outside IDLE/OVER SHALL be ignored.
REQ-027 Scores SHALL never exceed WIN_SCORE and never wrap.
REQ-028 frame_tick coincident with a state transition SHALL count only in the state holding it at that edge.

Reset
REQ-029 not_rst low at a clk edge SHALL force, at any point mid-match: state=IDLE, run=0, serve=0, serve_dir=1, scores=0, winner=00, counter=0, synchroniser flops=1 (released), pause flag cleared.

Configuration
REQ-030 Macro MATCH_PAUSE_EN defined: pause event in RALLY -> PAUSE (run=0, state and scores held); pause event in PAUSE -> RALLY; miss pulses ignored in PAUSE; start ignored in PAUSE.
REQ-031 Macro MATCH_PAUSE_EN undefined: pause_n SHALL be unused, PAUSE unreachable, behaviour otherwise identical.

Verification
REQ-032 Reset then start press -> serve pulse 1 cycle, state=1, run=0; after 60 frame_ticks state=2, run=1.
REQ-033 In RALLY pulse miss_left -> score_right 0->1, serve_dir=0, state=3, run=0; after 90 ticks state=1 with serve pulse.
REQ-034 Drive score_left to 6, then miss_right -> score_left=7, after 90 ticks state=4, winner=01; start -> scores 0, state=1.
REQ-035 miss_left and miss_right same cycle in RALLY -> scores unchanged, state=1, serve pulse, serve_dir unchanged.
REQ-036 Assert not_rst low during POINT with score 3:2 -> next cycle state=0, scores 0:0, run=0; start held low continuously -> only one start event.
REQ-037 With MATCH_PAUSE_EN: pause in RALLY -> state=5, run=0, miss_left ignored; second pause -> state=2, run=1, scores unchanged.
